// File: rtl/counter_countdown_if.sv
// Control/status bundle for the countdown timer: load/tick/ack inputs and
// count, terminal-count pulse, sticky irq and running status outputs.
interface counter_countdown_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d;
    logic             load;
    logic             enable;
    logic             periodic;
    logic             ack;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             irq;
    logic             running;

    modport master (
        output d, load, enable, periodic, ack,
        input  q, tc, irq, running
    );

    modport slave (
        input  d, load, enable, periodic, ack,
        output q, tc, irq, running
    );
endinterface

// File: rtl/counter_countdown.sv
// Loadable down-counter/timer with one-shot or periodic reload, a one-cycle
// terminal-count pulse, a sticky irq flag and an optional output delay line.
module counter_countdown #(
    parameter int MAX   = 16,
    parameter int WIDTH = (MAX > 2) ? $clog2(MAX) : 1,
    parameter int DELAY = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    counter_countdown_if.slave bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MAX - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam bit               CLAMP = (MAX != (1 << WIDTH));
    localparam int               DW    = WIDTH + 1;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] rld;
    logic [WIDTH-1:0] dv;
    logic             tc_r;
    logic             irq_r;
    logic             terminal;

    // NOTE: combinational blocks assign a default first so no path leaves dv unassigned (no latch).
    always_comb begin
        dv = bus.d;
        if (CLAMP && (bus.d > TOP)) begin
            dv = TOP;
        end
    end

    // A load on the terminal cycle wins, so the terminal event never happens.
    assign terminal = (state == ST_RUN) && bus.enable && !bus.load && (cnt == ONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rld   <= '0;
            tc_r  <= 1'b0;
            irq_r <= 1'b0;
        end else begin
            tc_r <= terminal;

            if (terminal) begin
                irq_r <= 1'b1;
            end else if (bus.ack) begin
                irq_r <= 1'b0;
            end

            if (bus.load) begin
                cnt   <= dv;
                rld   <= dv;
                state <= (dv != '0) ? ST_RUN : ST_IDLE;
            end else if ((state == ST_RUN) && bus.enable) begin
                if (cnt == ONE) begin
                    if (bus.periodic) begin
                        cnt <= rld;
                    end else begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                end else begin
                    cnt <= cnt - ONE;
                end
            end
        end
    end

    logic [DW-1:0] line_in;
    logic [DW-1:0] line_out;

    assign line_in = {tc_r, cnt};

    generate
        if (DELAY == 0) begin : g_no_delay
            assign line_out = line_in;
        end else begin : g_delay
            logic [DW-1:0] stage [DELAY];

            // NOTE: the delay stages are reset too, so q and tc read 0 straight out of reset.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DELAY; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= line_in;
                    for (int i = 1; i < DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign line_out = stage[DELAY-1];
        end
    endgenerate

    assign bus.q       = line_out[WIDTH-1:0];
    assign bus.tc      = line_out[WIDTH];
    assign bus.irq     = irq_r;
    assign bus.running = (state == ST_RUN);
endmodule

// File: tb/tb_counter_countdown.sv
// Scoreboard bench: two timer configurations (MAX=16/DELAY=0 and MAX=10/DELAY=2)
// driven identically, checked against a behavioural timer model.
module tb_counter_countdown;
    typedef struct {
        int q;
        int tc;
        int irq;
        int run;
    } exp_t;

    logic clk;
    logic rst_n;

    counter_countdown_if #(.WIDTH(4)) bus0 ();
    counter_countdown_if #(.WIDTH(4)) bus1 ();

    counter_countdown #(.MAX(16), .DELAY(0)) dut0 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus0)
    );

    counter_countdown #(.MAX(10), .DELAY(2)) dut1 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
        end
    endtask

    // Behavioural model: remaining count, reload value, active flag, sticky
    // flag, plus a history of (count, pulse) after each edge for the delay line.
    int max_v [2] = '{16, 10};
    int dly_v [2] = '{0, 2};
    int m_cnt [2];
    int m_rld [2];
    int m_run [2];
    int m_irq [2];
    int h_cnt [2][4];
    int h_tc  [2][4];

    exp_t sb0[$];
    exp_t sb1[$];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_rld[k] = 0;
            m_run[k] = 0;
            m_irq[k] = 0;
            for (int j = 0; j < 4; j++) begin
                h_cnt[k][j] = 0;
                h_tc[k][j]  = 0;
            end
        end
    endtask

    task automatic model_step(input int d, input bit load, input bit en,
                              input bit per, input bit ack);
        for (int k = 0; k < 2; k++) begin
            int  start;
            bit  fired;
            start = (d > max_v[k] - 1) ? max_v[k] - 1 : d;
            fired = 1'b0;
            if (load) begin
                m_cnt[k] = start;
                m_rld[k] = start;
                m_run[k] = (start != 0);
            end else if (m_run[k] != 0 && en) begin
                if (m_cnt[k] == 1) begin
                    fired    = 1'b1;
                    m_cnt[k] = per ? m_rld[k] : 0;
                    m_run[k] = per;
                end else begin
                    m_cnt[k] = m_cnt[k] - 1;
                end
            end
            if (fired) m_irq[k] = 1;
            else if (ack) m_irq[k] = 0;
            for (int j = 3; j > 0; j--) begin
                h_cnt[k][j] = h_cnt[k][j-1];
                h_tc[k][j]  = h_tc[k][j-1];
            end
            h_cnt[k][0] = m_cnt[k];
            h_tc[k][0]  = fired;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.q   = h_cnt[k][dly_v[k]];
            e.tc  = h_tc[k][dly_v[k]];
            e.irq = m_irq[k];
            e.run = m_run[k];
            if (k == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
    endtask

    // One clock cycle of stimulus, driven at the falling edge.
    task automatic cycle(input bit rst, input int d, input bit load, input bit en,
                         input bit per, input bit ack);
        @(negedge clk);
        rst_n         = rst;
        bus0.d        = 4'(d);
        bus1.d        = 4'(d);
        bus0.load     = load;
        bus1.load     = load;
        bus0.enable   = en;
        bus1.enable   = en;
        bus0.periodic = per;
        bus1.periodic = per;
        bus0.ack      = ack;
        bus1.ack      = ack;
        if (!rst) model_reset();
        else      model_step(d, load, en, per, ack);
        push_expected();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic compare(input string tag, input exp_t e, input int q, input int tc,
                           input int irq, input int run);
        check({tag, ".q"}, q, e.q);
        check({tag, ".tc"}, tc, e.tc);
        check({tag, ".irq"}, irq, e.irq);
        check({tag, ".running"}, run, e.run);
    endtask

    // Monitor: every cycle the timers present a new output set, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                compare("dut0", e, int'(bus0.q), int'(bus0.tc), int'(bus0.irq), int'(bus0.running));
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                compare("dut1", e, int'(bus1.q), int'(bus1.tc), int'(bus1.irq), int'(bus1.running));
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus0.d        = '0;
        bus1.d        = '0;
        bus0.load     = 1'b0;
        bus1.load     = 1'b0;
        bus0.enable   = 1'b0;
        bus1.enable   = 1'b0;
        bus0.periodic = 1'b0;
        bus1.periodic = 1'b0;
        bus0.ack      = 1'b0;
        bus1.ack      = 1'b0;
        model_reset();

        // Reset state, then first cycles after release.
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Reset mid-count: load 9, three ticks, then drop reset between edges.
        cycle(1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst.q0", int'(bus0.q), 0);
        check("async_rst.run0", int'(bus0.running), 0);
        check("async_rst.irq0", int'(bus0.irq), 0);
        check("async_rst.q1", int'(bus1.q), 0);
        check("async_rst.run1", int'(bus1.running), 0);
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // One-shot from 5, ack afterwards.
        cycle(1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Periodic from 3 for 12 ticks.
        cycle(1'b1, 3, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);

        // Gated enable from 4.
        cycle(1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 0, 1'b0, (i % 2) == 0, 1'b0, 1'b0);
        cycle(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Load on the terminal cycle: reload to 7, no pulse, irq untouched.
        cycle(1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 7, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Ack on the terminal cycle: set wins.
        cycle(1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(3);
        cycle(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Load of zero stays idle with no pulse.
        cycle(1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Clamp (second timer) and delay line.
        cycle(1'b1, 15, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) cycle(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 299) != 0);
            cycle(r, int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain0", sb0.size(), 0);
        check("scoreboard_drain1", sb1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
